// File: rtl/mdu_pkg.sv
// Shared encodings and defaults for the multiply/divide sequencer.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_e;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } mdu_state_e;

  localparam int unsigned MduMultCycles = 5;
  localparam int unsigned MduDivCycles  = 10;

  // Counter holds N-1, so a width covering the larger latency is enough.
  function automatic int unsigned mdu_cnt_width(input int unsigned mult_n, input int unsigned div_n);
    int unsigned m;
    m = (mult_n > div_n) ? mult_n : div_n;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/mdu_cnt.sv
// Loadable down-counter that stops at zero; only built with MDU_MULTICYCLE_EN.
`ifdef MDU_MULTICYCLE_EN
module mdu_cnt #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] value,
  output logic             zero
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule
`endif

// File: rtl/mdu_seq_ctrl.sv
// HI/LO owner for the MIPS pipeline. With MDU_MULTICYCLE_EN defined, MULT/DIV
// results land after a counted latency with busy raised; otherwise they write at once.
module mdu_seq_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MduMultCycles,
  parameter int unsigned DIV_CYCLES  = MduDivCycles
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic               op_valid, accept;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] res_hi, res_lo;

  assign op_valid = (op != MDU_NONE) && (op != 3'd7);
  assign prod_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u   = {32'd0, a} * {32'd0, b};

  // Divide by zero falls through to the current HI/LO, so completion is a no-op.
  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    case (op)
      MDU_MULT:  {res_hi, res_lo} = prod_s;
      MDU_MULTU: {res_hi, res_lo} = prod_u;
      MDU_DIV: begin
        if (b != '0) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            res_lo = a;
            res_hi = '0;
          end else begin
            res_lo = $signed(a) / $signed(b);
            res_hi = $signed(a) % $signed(b);
          end
        end
      end
      MDU_DIVU: begin
        if (b != '0) begin
          res_lo = a / b;
          res_hi = a % b;
        end
      end
      default: ;
    endcase
  end

`ifdef MDU_MULTICYCLE_EN
  localparam int unsigned CntW = mdu_cnt_width(MULT_CYCLES, DIV_CYCLES);

  mdu_state_e        state_q, state_d;
  logic [31:0]       hi_n_q, hi_n_d, lo_n_q, lo_n_d;
  logic              cnt_load, cnt_zero, is_div;
  logic [CntW-1:0]   cnt_value;

  assign is_div    = (op == MDU_DIV) || (op == MDU_DIVU);
  assign cnt_value = is_div ? CntW'(DIV_CYCLES - 1) : CntW'(MULT_CYCLES - 1);
  assign accept    = start & ~flush & (state_q == StIdle) & op_valid;
  assign busy      = (state_q == StRun);

  mdu_cnt #(
    .Width(CntW)
  ) u_cnt (
    .clk  (clk),
    .reset(reset),
    .load (cnt_load),
    .value(cnt_value),
    .zero (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_n_d   = hi_n_q;
    lo_n_d   = lo_n_q;
    cnt_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (op == MDU_MTHI) begin
            hi_d = a;
          end else if (op == MDU_MTLO) begin
            lo_d = a;
          end else begin
            hi_n_d   = res_hi;
            lo_n_d   = res_lo;
            cnt_load = 1'b1;
            state_d  = StRun;
          end
        end
      end
      StRun: begin
        if (cnt_zero) begin
          hi_d    = hi_n_q;
          lo_d    = lo_n_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      hi_q    <= '0;
      lo_q    <= '0;
      hi_n_q  <= '0;
      lo_n_q  <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_n_q  <= hi_n_d;
      lo_n_q  <= lo_n_d;
    end
  end
`else
  logic [1:0] unused_cfg;
  assign unused_cfg = {MULT_CYCLES[0], DIV_CYCLES[0]};

  assign accept = start & ~flush & op_valid;
  assign busy   = 1'b0;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (accept) begin
      if (op == MDU_MTHI) begin
        hi_d = a;
      end else if (op == MDU_MTLO) begin
        lo_d = a;
      end else begin
        hi_d = res_hi;
        lo_d = res_lo;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
`endif

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Scoreboard bench for mdu_seq_ctrl; expectations are due-cycle stamped and
// checked by an independent monitor. Latencies follow MDU_MULTICYCLE_EN.
module tb_mdu_seq_ctrl;
  import mdu_pkg::*;

  localparam int unsigned MulC = 5;
  localparam int unsigned DivC = 10;
`ifdef MDU_MULTICYCLE_EN
  localparam int MulL = MulC;
  localparam int DivL = DivC;
`else
  localparam int MulL = 0;
  localparam int DivL = 0;
`endif

  logic        clk, reset, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b, hi, lo;
  logic        busy;

  mdu_seq_ctrl #(
    .MULT_CYCLES(MulC),
    .DIV_CYCLES (DivC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .flush(flush),
    .hi   (hi),
    .lo   (lo),
    .busy (busy)
  );

  typedef struct {
    int          due;
    bit          ck_hl;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: cyc=%0d, required finish before timeout", cyc);
    $fatal(1, "timeout");
  end

  // Monitor: compare every entry whose due cycle has arrived.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        n_tests++;
        if (sb[i].due < cyc || busy !== sb[i].busy ||
            (sb[i].ck_hl && (hi !== sb[i].hi || lo !== sb[i].lo))) begin
          n_fail++;
          $display("FAIL %s: cyc=%0d got hi=%h lo=%h busy=%b, want hi=%h lo=%h busy=%b (due %0d)",
                   sb[i].name, cyc, hi, lo, busy, sb[i].hi, sb[i].lo, sb[i].busy, sb[i].due);
        end
        sb.delete(i);
      end
    end
  end

  task automatic push(input int due, input bit ck_hl, input logic [31:0] h, input logic [31:0] l,
                      input logic bz, input string nm);
    exp_t e;
    e.due = due; e.ck_hl = ck_hl; e.hi = h; e.lo = l; e.busy = bz; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input bit fl, input int lat,
                        input logic [31:0] eh, input logic [31:0] el,
                        input bit mid_fl, input bit mid_st);
    int c0;
    c0 = cyc;
    for (int k = 1; k <= lat; k++) push(c0 + k, 1'b0, '0, '0, 1'b1, {nm, "_busy"});
    push(c0 + lat + 1, 1'b1, eh, el, 1'b0, nm);
    start = 1'b1; flush = fl; op = o; a = av; b = bv;
    tick();
    start = 1'b0; flush = 1'b0; op = MDU_NONE;
    for (int k = 0; k < lat; k++) begin
      flush = mid_fl && (k == 1);
      start = mid_st && (k == 2);
      if (mid_st && (k == 2)) begin
        op = MDU_MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
      end
      tick();
      start = 1'b0; op = MDU_NONE;
    end
    flush = 1'b0;
  endtask

  initial begin
    int c0;
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = MDU_NONE; a = '0; b = '0;
    tick(); tick();
    reset = 1'b0;
    push(cyc, 1'b1, 32'h0, 32'h0, 1'b0, "reset_state");
    tick();

    run_op("mult_neg",   MDU_MULT,  32'hFFFF_FFFE, 32'd3, 1'b0, MulL,
           32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 1'b0);
    run_op("divu_7_2",   MDU_DIVU,  32'd7, 32'd2, 1'b0, DivL, 32'd1, 32'd3, 1'b0, 1'b0);
    run_op("div_m7_2",   MDU_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0, DivL,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op("mthi",       MDU_MTHI,  32'h1234, 32'd0, 1'b0, 0, 32'h1234, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op("div_by_0",   MDU_DIV,   32'h55, 32'd0, 1'b0, DivL, 32'h1234, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op("flush_mult", MDU_MULT,  32'd5, 32'd5, 1'b1, 0, 32'h1234, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op("multu_fl",   MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, MulL,
           32'd1, 32'hFFFF_FFFE, 1'b1, 1'b0);
    run_op("div_ovf",    MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, DivL,
           32'd0, 32'h8000_0000, 1'b0, 1'b0);
    run_op("mtlo",       MDU_MTLO,  32'hCAFE, 32'd0, 1'b0, 0, 32'd0, 32'hCAFE, 1'b0, 1'b0);
    run_op("flush_mthi", MDU_MTHI,  32'hDEAD, 32'd0, 1'b1, 0, 32'd0, 32'hCAFE, 1'b0, 1'b0);
    run_op("mult_ign",   MDU_MULT,  32'd3, 32'd4, 1'b0, MulL, 32'd0, 32'hC, 1'b0, 1'b1);
    push(cyc + 1, 1'b1, 32'd0, 32'hC, 1'b0, "mult_ign_after");
    tick();
    run_op("multu_2p16", MDU_MULTU, 32'h1_0000, 32'h1_0000, 1'b0, MulL, 32'd1, 32'd0, 1'b0, 1'b0);
    run_op("mult_max",   MDU_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, MulL,
           32'h3FFF_FFFF, 32'h1, 1'b0, 1'b0);

    // Reset three cycles into a MULT must clear everything and drop the result.
    c0 = cyc;
    for (int k = 1; k <= 3 && k <= MulL; k++) push(c0 + k, 1'b0, '0, '0, 1'b1, "rst_run_busy");
    push(c0 + 4, 1'b1, 32'd0, 32'd0, 1'b0, "rst_run_clear");
    start = 1'b1; op = MDU_MULT; a = 32'd6; b = 32'd7;
    tick();
    start = 1'b0; op = MDU_NONE;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (MulL + 4) tick();
    push(cyc, 1'b1, 32'd0, 32'd0, 1'b0, "rst_run_stay");
    tick();

    run_op("divu_post",  MDU_DIVU,  32'd100, 32'd7, 1'b0, DivL, 32'd2, 32'd14, 1'b0, 1'b0);

    repeat (3) tick();
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      n_fail += sb.size();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_seq_ctrl.md
# mdu_seq_ctrl

Multi-cycle multiply/divide sequencer owning the HI/LO register pair for the 5-stage MIPS pipeline. It accepts one operation per start pulse from the E stage and models the architectural latency with a countdown. It exposes `busy` to the hazard controller so that MDU-related instructions in D stall. Starts are suppressed while an interrupt/exception flush is asserted, so a squashed E-stage instruction never alters HI/LO.

## Interface

**Parameters**
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU.

**Ports**
- `clk`  in  1: single clock. All state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: E stage issues `op` this cycle.
- `op`  in  3: operation code. NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, 7=reserved (treated as NONE).
- `a`  in  32: forwarded rs value.
- `b`  in  32: forwarded rt value.
- `flush`  in  1: interrupt/exception request. Squashes a same-cycle `start`.
- `hi`  out  32: architectural HI register, registered.
- `lo`  out  32: architectural LO register, registered.
- `busy`  out  1: operation in flight. Registered.

## Operation

**States**
- IDLE:
  - An accepted start of MULT/MULTU/DIV/DIVU latches the result into shadow registers `hi_n`/`lo_n`, loads `cnt` = N−1, and goes to RUN.
  - An accepted start of MTHI/MTLO writes `a` into HI/LO directly at that edge and stays in IDLE.
- RUN:
  - `cnt` decrements each cycle.
  - On the edge where `cnt`==0, HI←`hi_n`, LO←`lo_n`, and the state goes to IDLE.
- **Accepted start** = `start` & ~`flush` & state==IDLE & `op`∈{1..6}.
- **Arithmetic:**
  - MULT: 64-bit signed product, HI=[63:32], LO=[31:0].
  - MULTU: 64-bit unsigned product, HI=[63:32], LO=[31:0].
  - DIV: LO=quotient, HI=remainder, truncation toward zero, remainder takes the sign of the dividend.
  - DIVU: LO=quotient, HI=remainder, unsigned.
- **Boundaries:**
  - Divide with `b`==0: the operation still runs DIV_CYCLES with busy=1, but HI/LO are left unchanged at completion.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wrap, no trap).
  - `start` while RUN: ignored, no state change. The hazard controller guarantees this never happens; the bench checks it anyway.
  - `flush` during RUN: no effect. The in-flight operation belongs to an older, committed instruction and completes.
  - `start` & `flush` in the same cycle: start dropped, including MTHI/MTLO.
  - `reset` during RUN: returns to IDLE immediately. HI, LO, `cnt`, shadows and busy are all cleared.
- **Reset values:** `hi`=0, `lo`=0, `busy`=0, state IDLE.

## Timing

- Accepted MULT at edge t:
  - `busy`=1 in cycles t+1 … t+MULT_CYCLES.
  - HI/LO take the new values at the edge closing cycle t+MULT_CYCLES.
  - `busy`=0 from cycle t+MULT_CYCLES+1.
- DIV is the same with DIV_CYCLES.
- MTHI/MTLO: visible on `hi`/`lo` the cycle after the accepting edge. `busy` stays 0.
- `hi`/`lo` are combinationally readable (MFHI/MFLO) and hold old values throughout RUN.
- A new start is accepted in the first cycle in which `busy`=0, so back-to-back operations are N+1 edges apart.
- The hazard controller stalls D on `busy` | `start`.

## Configuration

- `MDU_MULTICYCLE_EN` defined:
  - Counted latency as above.
- `MDU_MULTICYCLE_EN` undefined:
  - RUN state and counter are omitted.
  - An accepted MULT/DIV writes HI/LO at the accepting edge, with the same arithmetic and div-by-zero rules.
  - `busy` is tied to 0.
  - MULT_CYCLES/DIV_CYCLES are ignored.

## Structure

- Shared package `mdu_pkg`:
  - `op` encodings MDU_NONE … MDU_MTLO.
  - State encoding IDLE/RUN.
  - Default cycle constants.
- One sub-module, `mdu_cnt`:
  - Loadable down-counter with width $clog2(max(MULT_CYCLES, DIV_CYCLES)).
  - Ports: load, value, zero.
  - Omitted when `MDU_MULTICYCLE_EN` is undefined.
- Arithmetic stays inline in `mdu_seq_ctrl`.

## Test plan

- MULT a=0xFFFFFFFE (−2), b=3, start at t → busy high for cycles t+1..t+5; at t+6: hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
- DIVU a=7, b=2 → after 10 busy cycles: lo=3, hi=1. Then DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- MTHI a=0x1234 then DIV b=0 → hi=0x1234 after 1 cycle; busy runs 10 cycles; hi/lo unchanged afterwards.
- start=1 with flush=1 and op=MULT, a=b=5 → busy stays 0, hi/lo unchanged. Flush pulsed mid-RUN of MULTU 0xFFFFFFFF×2 → completes with hi=1, lo=0xFFFFFFFE.
- start MULT, then reset at cycle t+3 → next cycle: busy=0, hi=lo=0. Start repeated at cycle t+3 of RUN → ignored, result equals the first operation only.
- Build without `MDU_MULTICYCLE_EN`: MULTU 0x10000×0x10000 → hi=1, lo=0 one cycle after start; busy never asserted.
